// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding and the flag bundle that the
// flag register downstream also uses.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic cout;
    logic overflow;
    logic zero;
    logic negative;
  } alu_flags_t;

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
// The slave modport is the arithmetic block; the master modport is the datapath side.
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, A, B, cin, sub, out_ready,
    input  in_ready, out_valid, result, cout, overflow, zero, negative
  );

  modport slave (
    input  in_valid, A, B, cin, sub, out_ready,
    output in_ready, out_valid, result, cout, overflow, zero, negative
  );
endinterface

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple slice. Also exports the carry into its MSB
// so the final slice can form signed overflow.
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             c_msb,
  output logic             is_zero
);
  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign co      = c[CHUNK];
  assign c_msb   = c[CHUNK-1];
  assign is_zero = ~|sum;
endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: an operand register followed by
// STAGES registered carry-chain slices, with a single global stall enable.
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic               clk,
  input logic               rst_n,
  pipelined_addsub_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  // Stage k holds an operation waiting for slice k: operands travel whole,
  // finished low chunks accumulate in sum_q, carry and running zero ride along.
  logic             v_q   [STAGES];
  logic             v_d   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic             c_q   [STAGES];
  logic             c_d   [STAGES];
  logic             z_q   [STAGES];
  logic             z_d   [STAGES];

  logic [CHUNK-1:0] ch_sum  [STAGES];
  logic             ch_co   [STAGES];
  logic             ch_cmsb [STAGES];
  logic             ch_z    [STAGES];
  logic [WIDTH-1:0] part    [STAGES];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;
  logic             en;

  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a       (a_q[k][k*CHUNK +: CHUNK]),
      .b       (b_q[k][k*CHUNK +: CHUNK]),
      .ci      (c_q[k]),
      .sum     (ch_sum[k]),
      .co      (ch_co[k]),
      .c_msb   (ch_cmsb[k]),
      .is_zero (ch_z[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      v_d[k]   = v_q[k];
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      sum_d[k] = sum_q[k];
      c_d[k]   = c_q[k];
      z_d[k]   = z_q[k];
      part[k]  = sum_q[k];
      part[k][k*CHUNK +: CHUNK] = ch_sum[k];
    end
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;

    if (en) begin
      v_d[0]   = bus.in_valid;
      a_d[0]   = bus.A;
      b_d[0]   = (bus.sub == OP_ADD) ? bus.B : ~bus.B;
      c_d[0]   = bus.cin ^ (bus.sub == OP_SUB);
      sum_d[0] = '0;
      z_d[0]   = 1'b1;
      for (int k = 1; k < STAGES; k++) begin
        v_d[k]   = v_q[k-1];
        a_d[k]   = a_q[k-1];
        b_d[k]   = b_q[k-1];
        sum_d[k] = part[k-1];
        c_d[k]   = ch_co[k-1];
        z_d[k]   = z_q[k-1] & ch_z[k-1];
      end
      // A bubble reaching the output clears result and flags so zero stays low.
      out_valid_d = v_q[STAGES-1];
      result_d    = '0;
      flags_d     = '0;
      if (v_q[STAGES-1]) begin
        result_d         = part[STAGES-1];
        flags_d.cout     = ch_co[STAGES-1];
        flags_d.overflow = ch_co[STAGES-1] ^ ch_cmsb[STAGES-1];
        flags_d.zero     = z_q[STAGES-1] & ch_z[STAGES-1];
        flags_d.negative = part[STAGES-1][WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        c_q[k]   <= 1'b0;
        z_q[k]   <= 1'b0;
      end
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= v_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
        c_q[k]   <= c_d[k];
        z_q[k]   <= z_d[k];
      end
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cout      = flags_q.cout;
  assign bus.overflow  = flags_q.overflow;
  assign bus.zero      = flags_q.zero;
  assign bus.negative  = flags_q.negative;
endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined two's-complement adder/subtractor for the RISC datapath. It replaces the fixed 32-bit single-cycle ripple adder wherever the carry chain limits clock frequency. The block splits the carry chain into `STAGES` registered slices, accepts one operation per cycle under a valid/ready handshake, and returns the result together with carry, overflow, zero and negative flags. It sits between the ALU operand muxes and the writeback/flag register.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; must be a multiple of `STAGES`.
- `STAGES`, 4, number of pipeline slices; chunk width `CHUNK = WIDTH/STAGES`; range 1..`WIDTH`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  block accepts the operation this cycle.
- `A`  in  `WIDTH`  operand A.
- `B`  in  `WIDTH`  operand B.
- `cin`  in  1  carry/borrow-in for multiword chaining.
- `sub`  in  1  0 = add, 1 = subtract.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  `WIDTH`  sum or difference.
- `cout`  out  1  carry out of the MSB (for subtract, 1 = no borrow).
- `overflow`  out  1  signed overflow.
- `zero`  out  1  `result == 0`.
- `negative`  out  1  `result[WIDTH-1]`.

## Operation
- Computation: `result = A + (sub ? ~B : B) + (cin ^ sub)`, modulo 2^`WIDTH`.
  - `sub=1, cin=0` gives A−B.
  - `sub=1, cin=1` gives A−B−1 (borrow-in).
- Slice k (k = 0..`STAGES`-1) computes bits `[k*CHUNK +: CHUNK]` using the carry registered by slice k-1.
- Finished low chunks and unprocessed high operand bits travel forward in skew registers alongside each slice.
- `overflow` = carry into the MSB XOR carry out of the MSB, taken in the final slice.
- `zero`: each slice ANDs "chunk is zero" into a running flag that travels with the operation.
- The `sub`-adjusted B and the effective carry-in are formed at the input, before slice 0.
- Global enable `en = !out_valid || out_ready`.
  - When `en` = 0, every pipeline register holds, including valid bits and bubbles.
  - `in_ready = en`.
- Transfer rules:
  - An operation is accepted when `in_valid && in_ready`.
  - A result is consumed when `out_valid && out_ready`.
- Operations complete in acceptance order. Nothing is dropped or duplicated.
- Bubbles are not collapsed. An empty stage that sits behind a stalled output stays empty.

## Timing
- Latency: an operation accepted at edge n gives `out_valid` = 1 with its result after edge n+`STAGES`. For `STAGES`=1 that is the next cycle.
- Throughput: one operation per cycle while `out_ready` = 1.
- Outputs are driven directly from registers. There is no combinational path from `A`, `B`, `cin` or `sub` to any output.
- `in_ready` depends combinationally on `out_ready` only.
- Reset values:
  - All valid bits are 0.
  - `result`, `cout`, `overflow`, `zero` and `negative` are 0. `zero` is 0 while `out_valid` = 0.
  - `in_ready` is 1.
- Reset asserted mid-stream: all in-flight operations are discarded immediately (asynchronous). No result for them appears after release.
- Simultaneous accept and consume with the pipeline full: both occur in the same cycle and the pipeline advances.
- `out_valid` = 1 and `out_ready` = 0: `result` and all flags hold stable until consumed.
- Wrap-around: the sum wraps modulo 2^`WIDTH`. `cout` reports the carry out of the MSB.

## Structure
- Shared package `alu_pkg`:
  - op encoding constants `OP_ADD = 1'b0`, `OP_SUB = 1'b1`;
  - flag bundle typedef `alu_flags_t` {`cout`, `overflow`, `zero`, `negative`}, which the flag register reuses.
- Sub-module `addsub_chunk`:
  - a `CHUNK`-bit combinational ripple slice built from the existing `full_adder` cell;
  - outputs the chunk sum, carry out, carry into its MSB and the chunk-zero flag.
- Top level: a generate loop over `STAGES` slices, plus the skew and valid registers and the stall logic.

## Test plan
Defaults `WIDTH`=32, `STAGES`=4 unless stated.
- Reset check: hold `rst_n` = 0 → `out_valid` = 0, `result` = 0, all flags 0, `in_ready` = 1.
- Carry wrap: `A`=0xFFFFFFFF, `B`=1, add, `cin`=0 → exactly 4 cycles later `result`=0, `cout`=1, `zero`=1, `overflow`=0, `negative`=0.
- Signed overflow:
  - `A`=0x7FFFFFFF + 1 → 0x80000000, `overflow`=1, `negative`=1, `cout`=0;
  - `A`=0x80000000 − 1 → 0x7FFFFFFF, `overflow`=1, `cout`=1.
- Borrow chaining: `A`=5, `B`=5, `sub`=1, `cin`=1 → 0xFFFFFFFF, `cout`=0, `negative`=1.
- Backpressure: 8 back-to-back random operations, `out_ready` low for 3 cycles mid-stream → `in_ready` follows `out_ready`, the output holds stable, and all 8 results match the model, in order, with none lost or duplicated.
- Parameter sweep and reset:
  - `WIDTH`=8/`STAGES`=1 (latency 1), `WIDTH`=64/`STAGES`=8 and `WIDTH`=32/`STAGES`=32: 10k random operations match the reference model;
  - `rst_n` pulsed with 3 operations in flight → no stale result appears after release.
